// File: rtl/gpio_sevenseg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_sevenseg_scan: 8-digit multiplexed hex display of a 32-bit register  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module gpio_sevenseg_scan #(
    parameter int unsigned DIV            = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic [31:0] Din,
    input  logic [7:0]  Dp,
    input  logic        En,
    input  logic        Blank_lz,
    output logic [6:0]  Seg,
    output logic        Dp_out,
    output logic [7:0]  An,
    output logic        Frame
);

    localparam logic [15:0] C_LAST    = 16'(DIV - 1);
    localparam logic [6:0]  C_SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic        C_DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [7:0]  C_AN_OFF  = AN_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  dps_q, dps_d;
    logic        frame_q, frame_d;
    logic [7:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        dpo_q, dpo_d;

    logic        w_tick;
    logic [7:0]  w_zero_from;
    logic [3:0]  w_nib;
    logic        w_blank;
    logic [6:0]  w_seg_log;
    logic        w_dp_log;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;  4'h1: p = 7'h06;  4'h2: p = 7'h5B;  4'h3: p = 7'h4F;
            4'h4: p = 7'h66;  4'h5: p = 7'h6D;  4'h6: p = 7'h7D;  4'h7: p = 7'h07;
            4'h8: p = 7'h7F;  4'h9: p = 7'h6F;  4'hA: p = 7'h77;  4'hB: p = 7'h7C;
            4'hC: p = 7'h39;  4'hD: p = 7'h5E;  4'hE: p = 7'h79;  default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Scan sequencing; the shadow only reloads at a frame boundary so no digit tears.
    always_comb begin
        w_tick   = (cnt_q == C_LAST);
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        dps_d    = dps_q;
        frame_d  = 1'b0;
        if (!En) begin
            cnt_d    = 16'd0;
            idx_d    = 3'd0;
            shadow_d = Din;
            dps_d    = Dp;
        end else if (w_tick) begin
            cnt_d = 16'd0;
            idx_d = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                shadow_d = Din;
                dps_d    = Dp;
                frame_d  = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // w_zero_from[k]: shadow nibbles k..7 are all zero.
    always_comb begin
        w_zero_from    = '0;
        w_zero_from[7] = (shadow_q[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            w_zero_from[k] = w_zero_from[k+1] && (shadow_q[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        w_nib     = shadow_q[{idx_q, 2'b00} +: 4];
        w_blank   = Blank_lz && (idx_q != 3'd0) && w_zero_from[idx_q];
        w_seg_log = w_blank ? 7'h00 : hex7(w_nib);
        w_dp_log  = !w_blank && dps_q[idx_q];
        if (En) begin
            an_d  = (8'd1 << idx_q) ^ C_AN_OFF;
            seg_d = w_seg_log ^ C_SEG_OFF;
            dpo_d = w_dp_log ^ C_DP_OFF;
        end else begin
            an_d  = C_AN_OFF;
            seg_d = C_SEG_OFF;
            dpo_d = C_DP_OFF;
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q    <= 16'd0;
            idx_q    <= 3'd0;
            shadow_q <= 32'd0;
            dps_q    <= 8'd0;
            frame_q  <= 1'b0;
            an_q     <= C_AN_OFF;
            seg_q    <= C_SEG_OFF;
            dpo_q    <= C_DP_OFF;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            dps_q    <= dps_d;
            frame_q  <= frame_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dpo_q    <= dpo_d;
        end
    end

    assign Seg    = seg_q;
    assign Dp_out = dpo_q;
    assign An     = an_q;
    assign Frame  = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_sevenseg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_gpio_sevenseg_scan: directed and random checks of gpio_sevenseg_scan   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_gpio_sevenseg_scan;

    localparam int TB_DIV = 4;
    localparam logic [6:0] PAT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        Rst_n;
    logic [31:0] Din;
    logic [7:0]  Dp;
    logic        En;
    logic        Blank_lz;
    logic [6:0]  Seg;
    logic        Dp_out;
    logic [7:0]  An;
    logic        Frame;

    int n_vec = 0;
    int n_err = 0;
    int frames = 0;

    // Reference state: enabled edges since enable/reset, and the latched display value.
    int          m_n  = 0;
    logic [31:0] m_sh = '0;
    logic [7:0]  m_dp = '0;

    gpio_sevenseg_scan #(
        .DIV            (TB_DIV),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .Rst_n    (Rst_n),
        .Din      (Din),
        .Dp       (Dp),
        .En       (En),
        .Blank_lz (Blank_lz),
        .Seg      (Seg),
        .Dp_out   (Dp_out),
        .An       (An),
        .Frame    (Frame)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input logic e_fr);
        n_vec++;
        assert (An === e_an) else begin
            n_err++; $error("FAIL %s An=%h expected %h", tag, An, e_an);
        end
        n_vec++;
        assert (Seg === e_seg) else begin
            n_err++; $error("FAIL %s Seg=%h expected %h", tag, Seg, e_seg);
        end
        n_vec++;
        assert (Dp_out === e_dp) else begin
            n_err++; $error("FAIL %s Dp_out=%b expected %b", tag, Dp_out, e_dp);
        end
        n_vec++;
        assert (Frame === e_fr) else begin
            n_err++; $error("FAIL %s Frame=%b expected %b", tag, Frame, e_fr);
        end
    endtask

    // One clock: predict from the display rules, clock, compare, advance the model.
    task automatic cycle(input string tag);
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_fr;
        logic        en_s;
        logic [31:0] din_s;
        logic [7:0]  dp_s;
        logic [31:0] upper;
        int          d;
        bit          blank;
        en_s  = En;
        din_s = Din;
        dp_s  = Dp;
        e_an  = 8'hFF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fr  = 1'b0;
        if (en_s) begin
            d     = (m_n / TB_DIV) % 8;
            upper = m_sh >> (4 * d);
            blank = Blank_lz && (d != 0) && (upper == 32'd0);
            e_an  = ~(8'd1 << d);
            e_seg = blank ? 7'h7F : ~PAT[upper[3:0]];
            e_dp  = blank ? 1'b1 : ~m_dp[d];
            e_fr  = ((m_n + 1) % (8 * TB_DIV)) == 0;
        end
        @(posedge clk);
        #1;
        check(tag, e_an, e_seg, e_dp, e_fr);
        if (Frame === 1'b1) frames++;
        if (en_s) begin
            if (e_fr) begin
                m_sh = din_s;
                m_dp = dp_s;
            end
            m_n++;
        end else begin
            m_n  = 0;
            m_sh = din_s;
            m_dp = dp_s;
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        Rst_n = 1'b0; En = 1'b0; Blank_lz = 1'b0; Din = '0; Dp = '0;
        #23;
        check("reset", 8'hFF, 7'h7F, 1'b1, 1'b0);
        @(negedge clk);
        Rst_n = 1'b1;
        run("post_reset_idle", 3);

        // Full scan of a fixed value, one frame pulse in the first 8*DIV cycles
        Din = 32'h89ABCDEF; Dp = 8'h00;
        cycle("scan_load");
        En = 1'b1;
        frames = 0;
        run("scan", 8 * TB_DIV);
        n_vec++;
        assert (frames == 1) else begin
            n_err++; $error("FAIL frame_count got %0d expected 1", frames);
        end
        run("scan_tail", 6);

        // Value changes mid-frame stay hidden until the frame boundary
        En = 1'b0; Din = 32'h0;
        cycle("tear_load");
        En = 1'b1;
        run("tear_a", 10);
        Din = 32'h12345678;
        run("tear_b", 8 * TB_DIV);

        // Leading-zero suppression on and off
        En = 1'b0; Din = 32'h00000A05; Dp = 8'hFF; Blank_lz = 1'b1;
        cycle("lz_load");
        En = 1'b1;
        run("lz_on", 8 * TB_DIV);
        Blank_lz = 1'b0;
        run("lz_off", 8 * TB_DIV);

        // Disable while digit 5 is lit, then restart
        En = 1'b0; Din = 32'h76543210; Dp = 8'hA5;
        cycle("en_load");
        En = 1'b1;
        run("en_scan", 5 * TB_DIV + 2);
        En = 1'b0;
        run("en_low", 2);
        En = 1'b1;
        run("en_restart", 10);

        // Asynchronous reset between edges, mid-frame
        run("areset_pre", 3);
        @(posedge clk);
        #3;
        Rst_n = 1'b0;
        #1;
        check("areset", 8'hFF, 7'h7F, 1'b1, 1'b0);
        m_n = 0; m_sh = '0; m_dp = '0;
        @(negedge clk);
        Rst_n = 1'b1;
        run("areset_post", 2 * TB_DIV);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r;
            r        = $urandom();
            Din      = r >> (4 * $urandom_range(0, 7));
            Dp       = 8'($urandom());
            Blank_lz = 1'($urandom_range(0, 1));
            En       = ($urandom_range(0, 19) != 0);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
